// File: rtl/mem_arbiter.sv
// Two-requester (IFU / LSU) round-robin arbiter in front of a single memory port.
// One transaction outstanding at a time: IDLE grants, REQ issues downstream, RESP waits.
module mem_arbiter #(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                if_req_valid,
  input  logic [ADDR_W-1:0]   if_req_addr,
  output logic                if_req_ready,
  output logic                if_resp_valid,
  output logic [DATA_W-1:0]   if_resp_rdata,
  input  logic                ls_req_valid,
  input  logic                ls_req_write,
  input  logic [ADDR_W-1:0]   ls_req_addr,
  input  logic [DATA_W-1:0]   ls_req_wdata,
  input  logic [DATA_W/8-1:0] ls_req_wmask,
  output logic                ls_req_ready,
  output logic                ls_resp_valid,
  output logic [DATA_W-1:0]   ls_resp_rdata,
  output logic                mem_req_valid,
  output logic                mem_req_write,
  output logic [ADDR_W-1:0]   mem_req_addr,
  output logic [DATA_W-1:0]   mem_req_wdata,
  output logic [DATA_W/8-1:0] mem_req_wmask,
  input  logic                mem_req_ready,
  input  logic                mem_resp_valid,
  input  logic [DATA_W-1:0]   mem_resp_rdata
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t                r_state;
  state_t                w_next_state;
  logic                  w_grant_if;
  logic                  w_grant_ls;
  logic                  r_last_ls;
  logic                  r_owner_ls;
  logic                  r_write;
  logic [ADDR_W-1:0]     r_addr;
  logic [DATA_W-1:0]     r_wdata;
  logic [DATA_W/8-1:0]   r_wmask;
  logic                  r_if_resp_valid;
  logic [DATA_W-1:0]     r_if_resp_rdata;
  logic                  r_ls_resp_valid;
  logic [DATA_W-1:0]     r_ls_resp_rdata;

  // Grants are gated by rst so nothing looks accepted while reset is being sampled.
  always_comb begin
    w_next_state = r_state;
    w_grant_if   = 1'b0;
    w_grant_ls   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (rst) begin
          w_grant_if = if_req_valid && (!ls_req_valid || r_last_ls);
          w_grant_ls = ls_req_valid && !w_grant_if;
        end else begin
          w_grant_if = 1'b0;
          w_grant_ls = 1'b0;
        end
        if (w_grant_if || w_grant_ls) begin
          w_next_state = S_REQ;
        end else begin
          w_next_state = S_IDLE;
        end
      end
      S_REQ: begin
        if (mem_req_ready) begin
          w_next_state = S_RESP;
        end else begin
          w_next_state = S_REQ;
        end
      end
      S_RESP: begin
        if (mem_resp_valid) begin
          w_next_state = S_IDLE;
        end else begin
          w_next_state = S_RESP;
        end
      end
      default: begin
        w_next_state = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // IFU transactions are always reads with an empty mask.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_last_ls  <= 1'b1;
      r_owner_ls <= 1'b0;
      r_write    <= 1'b0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_wmask    <= '0;
    end else if (w_grant_if) begin
      r_last_ls  <= 1'b0;
      r_owner_ls <= 1'b0;
      r_write    <= 1'b0;
      r_addr     <= if_req_addr;
      r_wdata    <= '0;
      r_wmask    <= '0;
    end else if (w_grant_ls) begin
      r_last_ls  <= 1'b1;
      r_owner_ls <= 1'b1;
      r_write    <= ls_req_write;
      r_addr     <= ls_req_addr;
      r_wdata    <= ls_req_wdata;
      r_wmask    <= ls_req_wmask;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_if_resp_valid <= 1'b0;
      r_if_resp_rdata <= '0;
      r_ls_resp_valid <= 1'b0;
      r_ls_resp_rdata <= '0;
    end else begin
      r_if_resp_valid <= 1'b0;
      r_ls_resp_valid <= 1'b0;
      if ((r_state == S_RESP) && mem_resp_valid) begin
        if (r_owner_ls) begin
          r_ls_resp_valid <= 1'b1;
          r_ls_resp_rdata <= r_write ? '0 : mem_resp_rdata;
        end else begin
          r_if_resp_valid <= 1'b1;
          r_if_resp_rdata <= mem_resp_rdata;
        end
      end
    end
  end

  assign if_req_ready  = w_grant_if;
  assign ls_req_ready  = w_grant_ls;
  assign if_resp_valid = r_if_resp_valid;
  assign if_resp_rdata = r_if_resp_rdata;
  assign ls_resp_valid = r_ls_resp_valid;
  assign ls_resp_rdata = r_ls_resp_rdata;
  assign mem_req_valid = (r_state == S_REQ);
  assign mem_req_write = r_write;
  assign mem_req_addr  = r_addr;
  assign mem_req_wdata = r_wdata;
  assign mem_req_wmask = r_wmask;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: memory responder model plus scoreboard queues
// filled at request acceptance and drained at memory handshake / response pulses.
module tb_mem_arbiter;

  logic        clk;
  logic        rst;
  logic        if_req_valid;
  logic [63:0] if_req_addr;
  logic        if_req_ready;
  logic        if_resp_valid;
  logic [63:0] if_resp_rdata;
  logic        ls_req_valid;
  logic        ls_req_write;
  logic [63:0] ls_req_addr;
  logic [63:0] ls_req_wdata;
  logic [7:0]  ls_req_wmask;
  logic        ls_req_ready;
  logic        ls_resp_valid;
  logic [63:0] ls_resp_rdata;
  logic        mem_req_valid;
  logic        mem_req_write;
  logic [63:0] mem_req_addr;
  logic [63:0] mem_req_wdata;
  logic [7:0]  mem_req_wmask;
  logic        mem_req_ready;
  logic        mem_resp_valid;
  logic [63:0] mem_resp_rdata;

  int cfg_stall;
  int cfg_resp_wait;
  int n_cmp;
  int n_err;

  typedef struct packed {
    logic        w;
    logic [63:0] a;
    logic [63:0] d;
    logic [7:0]  m;
  } req_t;

  req_t        req_q[$];
  logic [63:0] if_q[$];
  logic [63:0] ls_q[$];

  mem_arbiter #(.ADDR_W(64), .DATA_W(64)) dut (
    .clk(clk), .rst(rst),
    .if_req_valid(if_req_valid), .if_req_addr(if_req_addr), .if_req_ready(if_req_ready),
    .if_resp_valid(if_resp_valid), .if_resp_rdata(if_resp_rdata),
    .ls_req_valid(ls_req_valid), .ls_req_write(ls_req_write), .ls_req_addr(ls_req_addr),
    .ls_req_wdata(ls_req_wdata), .ls_req_wmask(ls_req_wmask), .ls_req_ready(ls_req_ready),
    .ls_resp_valid(ls_resp_valid), .ls_resp_rdata(ls_resp_rdata),
    .mem_req_valid(mem_req_valid), .mem_req_write(mem_req_write), .mem_req_addr(mem_req_addr),
    .mem_req_wdata(mem_req_wdata), .mem_req_wmask(mem_req_wmask), .mem_req_ready(mem_req_ready),
    .mem_resp_valid(mem_resp_valid), .mem_resp_rdata(mem_resp_rdata)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] memfn(input logic [63:0] a);
    if (a == 64'h0000_0000_8000_0000) return 64'h0000_0000_0010_0073;
    return a ^ 64'h5A5A_1234_0F0F_9876;
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Memory model: ready after cfg_stall cycles of valid, data cfg_resp_wait cycles after acceptance.
  initial begin
    logic        acc;
    logic [63:0] acc_addr;
    logic        pend;
    logic        in_req;
    logic [63:0] pend_data;
    int          wait_left;
    int          stall_left;
    mem_req_ready  = 1'b0;
    mem_resp_valid = 1'b0;
    mem_resp_rdata = 64'd0;
    pend = 1'b0; in_req = 1'b0; wait_left = 0; stall_left = 0; pend_data = 64'd0;
    forever begin
      @(negedge clk);
      acc      = mem_req_valid && mem_req_ready;
      acc_addr = mem_req_addr;
      @(posedge clk);
      #1;
      mem_resp_valid = 1'b0;
      if (acc) begin
        pend      = 1'b1;
        wait_left = cfg_resp_wait;
        pend_data = memfn(acc_addr);
      end
      if (pend) begin
        if (wait_left == 0) begin
          mem_resp_valid = 1'b1;
          mem_resp_rdata = pend_data;
          pend           = 1'b0;
        end else begin
          wait_left--;
        end
      end
      if (mem_req_valid) begin
        if (!in_req) begin
          in_req     = 1'b1;
          stall_left = cfg_stall;
        end
        if (stall_left > 0) begin
          mem_req_ready = 1'b0;
          stall_left--;
        end else begin
          mem_req_ready = 1'b1;
        end
      end else begin
        in_req        = 1'b0;
        mem_req_ready = 1'b0;
      end
    end
  end

  // Scoreboard monitor, sampling on the falling edge.
  initial begin
    logic        prev_hold;
    req_t        prev;
    req_t        e;
    logic [63:0] d;
    prev_hold = 1'b0;
    prev      = '0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        req_q.delete(); if_q.delete(); ls_q.delete();
        prev_hold = 1'b0;
      end else begin
        if (if_resp_valid) begin
          if (if_q.size() == 0) chk("if_resp_unexpected", 64'd1, 64'd0);
          else begin d = if_q.pop_front(); chk("if_rdata", if_resp_rdata, d); end
        end
        if (ls_resp_valid) begin
          if (ls_q.size() == 0) chk("ls_resp_unexpected", 64'd1, 64'd0);
          else begin d = ls_q.pop_front(); chk("ls_rdata", ls_resp_rdata, d); end
        end
        if (if_req_ready || ls_req_ready)
          chk("ready_exclusive", {62'd0, if_req_ready, ls_req_ready} & 64'd3 & {63'd0, if_req_ready & ls_req_ready}, 64'd0);
        if (prev_hold) begin
          chk("stall_valid", {63'd0, mem_req_valid}, 64'd1);
          chk("stall_addr", mem_req_addr, prev.a);
          chk("stall_wdata", mem_req_wdata, prev.d);
          chk("stall_wr_mask", {55'd0, mem_req_write, mem_req_wmask}, {55'd0, prev.w, prev.m});
        end
        if (mem_req_valid && mem_req_ready) begin
          if (req_q.size() == 0) chk("mem_req_unexpected", 64'd1, 64'd0);
          else begin
            e = req_q.pop_front();
            chk("mem_write", {63'd0, mem_req_write}, {63'd0, e.w});
            chk("mem_addr", mem_req_addr, e.a);
            chk("mem_wdata", mem_req_wdata, e.d);
            chk("mem_wmask", {56'd0, mem_req_wmask}, {56'd0, e.m});
          end
        end
        if (if_req_valid && if_req_ready) begin
          if_q.push_back(memfn(if_req_addr));
          req_q.push_back('{w: 1'b0, a: if_req_addr, d: 64'd0, m: 8'd0});
        end
        if (ls_req_valid && ls_req_ready) begin
          ls_q.push_back(ls_req_write ? 64'd0 : memfn(ls_req_addr));
          req_q.push_back('{w: ls_req_write, a: ls_req_addr, d: ls_req_wdata, m: ls_req_wmask});
        end
        prev_hold = mem_req_valid && !mem_req_ready;
        prev      = '{w: mem_req_write, a: mem_req_addr, d: mem_req_wdata, m: mem_req_wmask};
      end
    end
  end

  initial begin
    logic [63:0] exp_a;
    int          pulses;
    n_cmp = 0; n_err = 0;
    cfg_stall = 0; cfg_resp_wait = 0;
    rst = 1'b0;
    if_req_valid = 1'b0; if_req_addr = 64'd0;
    ls_req_valid = 1'b0; ls_req_write = 1'b0; ls_req_addr = 64'd0;
    ls_req_wdata = 64'd0; ls_req_wmask = 8'd0;

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_mem_valid", {63'd0, mem_req_valid}, 64'd0);
    chk("rst_resp_valids", {62'd0, if_resp_valid, ls_resp_valid}, 64'd0);
    chk("rst_if_rdata", if_resp_rdata, 64'd0);
    chk("rst_ls_rdata", ls_resp_rdata, 64'd0);
    chk("rst_mem_addr", mem_req_addr, 64'd0);
    chk("rst_mem_wdata", mem_req_wdata, 64'd0);
    chk("rst_mem_wr_mask", {55'd0, mem_req_write, mem_req_wmask}, 64'd0);
    chk("rst_readies", {62'd0, if_req_ready, ls_req_ready}, 64'd0);

    // Tie on the first cycle out of reset, then keep both valid for four grants.
    cyc();
    rst = 1'b1;
    if_req_valid = 1'b1; if_req_addr = 64'h0000_0000_8000_0000;
    ls_req_valid = 1'b1; ls_req_write = 1'b0; ls_req_addr = 64'h0000_0000_8000_0100;
    @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      chk("grant_if", {63'd0, if_req_ready}, {63'd0, (k % 2 == 0)});
      chk("grant_ls", {63'd0, ls_req_ready}, {63'd0, (k % 2 == 1)});
      cyc();
      if (k == 0) if_req_addr = 64'd0;
      exp_a = (k == 0) ? 64'h0000_0000_8000_0000 : ((k % 2 == 1) ? 64'h0000_0000_8000_0100 : 64'd0);
      @(negedge clk);
      chk("t1_mem_valid", {63'd0, mem_req_valid}, 64'd1);
      chk("t1_mem_addr", mem_req_addr, exp_a);
      chk("t1_mem_write", {63'd0, mem_req_write}, 64'd0);
      chk("t1_readies", {62'd0, if_req_ready, ls_req_ready}, 64'd0);
      cyc();
      if (k == 3) begin if_req_valid = 1'b0; ls_req_valid = 1'b0; end
      @(negedge clk);
      chk("t2_mem_valid", {63'd0, mem_req_valid}, 64'd0);
      chk("t2_no_resp", {62'd0, if_resp_valid, ls_resp_valid}, 64'd0);
      cyc();
      @(negedge clk);
      chk("t3_if_resp", {63'd0, if_resp_valid}, {63'd0, (k % 2 == 0)});
      chk("t3_ls_resp", {63'd0, ls_resp_valid}, {63'd0, (k % 2 == 1)});
      if (k == 0) chk("t3_if_rdata", if_resp_rdata, 64'h0000_0000_0010_0073);
    end

    // Store with memory ready held low for three cycles; IFU waits meanwhile.
    cfg_stall = 3;
    cyc();
    ls_req_valid = 1'b1; ls_req_write = 1'b1; ls_req_addr = 64'h0000_0000_8000_1000;
    ls_req_wdata = 64'hDEAD_BEEF_CAFE_F00D; ls_req_wmask = 8'hFF;
    @(negedge clk);
    chk("st_grant", {62'd0, if_req_ready, ls_req_ready}, 64'd1);
    cyc();
    ls_req_valid = 1'b0; ls_req_wdata = 64'd0; ls_req_write = 1'b0;
    if_req_valid = 1'b1; if_req_addr = 64'h0000_0000_8000_0300;
    pulses = 0;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      if (c <= 5) chk("st_readies", {62'd0, if_req_ready, ls_req_ready}, 64'd0);
      if (c == 2) begin
        chk("st_hold_addr", mem_req_addr, 64'h0000_0000_8000_1000);
        chk("st_hold_wdata", mem_req_wdata, 64'hDEAD_BEEF_CAFE_F00D);
        chk("st_hold_ready", {63'd0, mem_req_ready}, 64'd0);
      end
      if (ls_resp_valid) pulses++;
      cyc();
      if (c == 5) if_req_valid = 1'b0;
    end
    chk("st_pulses", pulses, 64'd1);
    cfg_stall = 0;

    // Reset while in RESP; the memory answers late, after reset.
    cfg_resp_wait = 3;
    if_req_valid = 1'b1; if_req_addr = 64'h0000_0000_8000_0200;
    @(negedge clk);
    chk("mr_grant", {62'd0, if_req_ready, ls_req_ready}, 64'd2);
    cyc();
    if_req_valid = 1'b0;
    cyc();
    rst = 1'b0;
    @(negedge clk);
    chk("mr_in_resp", {63'd0, mem_req_valid}, 64'd0);
    cyc();
    rst = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      chk("mr_no_resp", {62'd0, if_resp_valid, ls_resp_valid}, 64'd0);
      chk("mr_mem_valid", {63'd0, mem_req_valid}, 64'd0);
      if (c == 0) chk("mr_rdata_clr", if_resp_rdata, 64'd0);
      cyc();
    end
    cfg_resp_wait = 0;

    // After reset the IFU wins a tie again, then the LSU follows.
    if_req_valid = 1'b1; if_req_addr = 64'h0000_0000_8000_0200;
    ls_req_valid = 1'b1; ls_req_write = 1'b0; ls_req_addr = 64'h0000_0000_8000_0400;
    @(negedge clk);
    chk("pr_grant_if", {62'd0, if_req_ready, ls_req_ready}, 64'd2);
    cyc();
    if_req_valid = 1'b0;
    cyc();
    cyc();
    @(negedge clk);
    chk("pr_grant_ls", {62'd0, if_req_ready, ls_req_ready}, 64'd1);
    chk("pr_if_resp", {63'd0, if_resp_valid}, 64'd1);
    cyc();
    ls_req_valid = 1'b0;
    repeat (4) cyc();
    chk("sb_drain_req", req_q.size(), 64'd0);
    chk("sb_drain_if", if_q.size(), 64'd0);
    chk("sb_drain_ls", ls_q.size(), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
